mul_share_arbiter: RTL
======================

# mul_share_arbiter

Round-robin controller that shares one pipelined signed×unsigned multiplier instance (30-bit signed operand × 11-bit unsigned operand → 30-bit truncated product, one ce-gated register stage) among N_REQ requesters in the BNN accelerator datapath. It arbitrates the requesters, drives the multiplier's clock enable and operands, and tracks the in-flight operation. It returns each result tagged with the requester ID, with full backpressure. The multiplier sits outside this block and connects through the mul_* ports.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, ≥ clog2(N_REQ)
- A_W, 30, signed operand width (fixed to multiplier din0)
- B_W, 11, unsigned operand width (fixed to multiplier din1)
- P_W, 30, product width (fixed to multiplier dout)
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester operation valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle
- req_a  in  N_REQ*A_W  packed signed operands, requester i at [i*A_W +: A_W]
- req_b  in  N_REQ*B_W  packed unsigned operands, requester i at [i*B_W +: B_W]
- resp_valid  out  1  result valid
- resp_ready  in  1  result consumer ready
- resp_id  out  ID_W  requester index of current result
- resp_data  out  P_W  product, passed from mul_dout
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  A_W  multiplier operand A
- mul_din1  out  B_W  multiplier operand B
- mul_dout  in  P_W  multiplier registered product
- op_count  out  32  number of accepted operations, wraps at 2^32

## Operation
- The multiplier register is the single pipeline stage. The controller holds s1_valid and s1_id shadowing it.
- advance = !s1_valid || resp_ready. mul_ce = advance. The multiplier register loads only when advance is high, so a stalled result holds in the register.
- Arbitration: round-robin over req_valid, with the search starting at index (last_grant+1) mod N_REQ. last_grant resets to N_REQ-1, so requester 0 has first priority.
- grant is one-hot, computed combinationally. req_ready[i] = advance && grant[i]. A request is accepted when req_valid[i] && req_ready[i].
- mul_din0 and mul_din1 carry the granted requester's operands. They are 0 when no request is granted.
- On an accepting edge: s1_valid←1, s1_id←granted index, last_grant←granted index, op_count←op_count+1.
- On an advancing edge with no request: s1_valid←0. last_grant is unchanged.
- Requester i must hold req_valid, req_a and req_b stable until it sees req_ready[i]. It must not drop valid without being accepted.
- resp_valid = s1_valid. resp_id = s1_id. resp_data = mul_dout, which is the signed product truncated to its 30 LSBs.
- No arbitration state changes while advance is low.
- Reset asserted mid-operation: the in-flight result is dropped, s1_valid←0, last_grant←N_REQ-1, op_count←0.

## Timing
- Reset values: resp_valid 0, resp_id 0, op_count 0, last_grant N_REQ-1.
- While reset_n is low: req_ready all 0, mul_ce 0, mul_din0 0, mul_din1 0.
- Latency: a request accepted in cycle t gives resp_valid=1 with its data in cycle t+1.
- Throughput: one operation per cycle while resp_ready is held at 1.
- Backpressure, cycle with resp_valid=1 and resp_ready=0:
  - req_ready is all 0 and mul_ce is 0.
  - resp_id and resp_data are stable until a cycle with resp_ready=1.
- Simultaneous events:
  - In the cycle the current result is consumed (resp_valid && resp_ready), a new request can be accepted, and its result appears in the next cycle.
  - With all requesters continuously valid, grants rotate 0,1,2,3,0,… Any valid requester is served within N_REQ accepted operations.
- op_count wraps from 32'hFFFFFFFF to 0.

## Test plan
- Reset then single request:
  - Stimulus: reset_n low for 3 cycles, then release. Requester 2 sends a=-3, b=5.
  - Required: all outputs at reset values during reset. After release, req_ready=4'b0100 in the request cycle. Next cycle resp_valid=1, resp_id=2, resp_data=30'h3FFFFFF1. op_count=1.
- All four requesters valid continuously, resp_ready=1, for 8 cycles:
  - Grant order is 0,1,2,3,0,1,2,3 and resp_valid stays 1 back-to-back.
  - With a=i+1 and b=10 for requester i, results are 10, 20, 30, 40 repeating.
- Backpressure: hold resp_ready=0 for 5 cycles while results are pending:
  - req_ready stays 0 and mul_ce stays 0.
  - resp_data and resp_id stay constant.
  - The first cycle after resp_ready=1 accepts the next round-robin requester.
- Extreme values:
  - a=30'h1FFFFFFF, b=11'h7FF → resp_data=30'h1FFFF801.
  - a=30'h20000000, b=1 → resp_data=30'h20000000.
- Reset mid-operation:
  - Stimulus: assert reset_n low while resp_valid=1 and resp_ready=0.
  - Required: resp_valid drops to 0 immediately, without waiting for a clock edge. op_count reads 0. After release, requester 0 wins when all requesters are valid.
- op_count wrap:
  - Stimulus: drive the counter to 32'hFFFFFFFF, either by a backdoor force or a long run, then accept one request.
  - Required: op_count reads 0.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if
//   Requester/consumer bundle for the shared-multiplier arbiter.
//   req_valid/req_ready : per-requester handshake (N_REQ bits)
//   req_a / req_b       : packed operands, requester i at [i*A_W +: A_W] / [i*B_W +: B_W]
//   resp_valid/ready    : result handshake
//   resp_id / resp_data : requester index and product of the current result
//   modport slave  : the arbiter side
//   modport master : the requester/consumer side
interface mul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int A_W   = 30,
  parameter int B_W   = 11,
  parameter int P_W   = 30
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [P_W-1:0]       resp_data;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Round-robin sharing of one external pipelined signed x unsigned multiplier
//   (single ce-gated register stage) among N_REQ requesters. Results come back
//   tagged with the requester index, with full backpressure.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : requester/consumer handshake bundle (slave side)
//   mul_ce    : multiplier clock enable
//   mul_din0  : multiplier operand A (signed)
//   mul_din1  : multiplier operand B (unsigned)
//   mul_dout  : multiplier registered product
//   op_count  : accepted operations, wraps at 2^32
module mul_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int A_W   = 30,
  parameter int B_W   = 11,
  parameter int P_W   = 30
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mul_share_arbiter_if.slave    bus,
  output logic                  mul_ce,
  output logic [A_W-1:0]        mul_din0,
  output logic [B_W-1:0]        mul_din1,
  input  logic [P_W-1:0]        mul_dout,
  output logic [31:0]           op_count
);

  localparam int unsigned NR = N_REQ;

  // Occupancy of the multiplier register stage.
  typedef enum logic {S_EMPTY, S_FULL} s1_state_t;

  s1_state_t       state, state_nxt;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] last_grant;
  logic [31:0]     op_cnt;

  logic             advance;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [N_REQ-1:0] grant;
  logic             accept;

  assign advance = (state == S_EMPTY) || bus.resp_ready;
  assign accept  = advance && grant_any;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned     s;
    logic [ID_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    s         = 0;
    idx       = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      s   = (32'(last_grant) + 32'd1 + k) % NR;
      idx = ID_W'(s);
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Operands of the granted requester; zero when nothing is granted or in reset.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (reset_n && grant_any) begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (grant_idx == ID_W'(i)) begin
          mul_din0 = bus.req_a[i*A_W +: A_W];
          mul_din1 = bus.req_b[i*B_W +: B_W];
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_EMPTY;
    else          state <= state_nxt;
  end

  // Next state: stage refills on accept, drains on an idle advance, holds on stall.
  always_comb begin
    state_nxt = state;
    if (advance) state_nxt = grant_any ? S_FULL : S_EMPTY;
  end

  // Outputs. reset_n gates the handshake so nothing is offered while in reset,
  // even though an empty stage would otherwise advance.
  always_comb begin
    mul_ce         = reset_n && advance;
    bus.req_ready  = mul_ce ? grant : '0;
    bus.resp_valid = (state == S_FULL);
    bus.resp_id    = s1_id;
    bus.resp_data  = mul_dout;
  end

  // Tag, arbitration pointer and operation counter; only move on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_id      <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      op_cnt     <= '0;
    end else if (accept) begin
      s1_id      <= grant_idx;
      last_grant <= grant_idx;
      op_cnt     <= op_cnt + 32'd1;
    end
  end

  assign op_count = op_cnt;

endmodule
